// File: rtl/led_uart_reporter.sv
// led_uart_reporter: reports each change of the LED bus as an ASCII hex UART frame.
// Optional 'L' prefix byte enabled by defining LED_REPORT_PREFIX_EN.
module led_uart_reporter #(
   parameter int CLK_FREQ = 25_000_000,
   parameter int BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] leds_in,
   output logic       tx,
   output logic       busy
);

   localparam int DIV = CLK_FREQ / BAUD;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef LED_REPORT_PREFIX_EN
   localparam int NB = 4;
`else
   localparam int NB = 3;
`endif
   localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
   localparam logic [1:0]    LAST_BYT = 2'(NB - 1);

   generate
      if (DIV < 2) begin : g_div_chk
         $error("led_uart_reporter: CLK_FREQ/BAUD must be >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t        state_q;
   logic [7:0]    last_q;
   logic [7:0]    snap_q;
   logic [2:0]    bit_q;
   logic [1:0]    byte_q;
   logic [CW-1:0] cnt_q;
   logic          tx_q;
   logic          busy_q;

   logic [7:0]    cur_byte;
   logic [2:0]    nxt_bit;
   logic          wrap;

   function automatic logic [7:0] hex_digit(input logic [3:0] d);
      return (d < 4'd10) ? 8'h30 + {4'h0, d} : 8'h37 + {4'h0, d};
   endfunction

   // Byte of the frame currently being shifted, built from the snapshot only
   always_comb begin
      cur_byte = 8'h0A;
      unique case (byte_q)
`ifdef LED_REPORT_PREFIX_EN
         2'd0:    cur_byte = 8'h4C;
         2'd1:    cur_byte = hex_digit(snap_q[7:4]);
         2'd2:    cur_byte = hex_digit(snap_q[3:0]);
         default: cur_byte = 8'h0A;
`else
         2'd0:    cur_byte = hex_digit(snap_q[7:4]);
         2'd1:    cur_byte = hex_digit(snap_q[3:0]);
         default: cur_byte = 8'h0A;
`endif
      endcase
   end

   assign nxt_bit = bit_q + 3'd1;
   assign wrap    = (cnt_q == CNT_MAX);

   // Frame FSM with registered line and busy outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         last_q  <= 8'h00;
         snap_q  <= 8'h00;
         bit_q   <= 3'd0;
         byte_q  <= 2'd0;
         cnt_q   <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               if (leds_in != last_q) begin
                  snap_q  <= leds_in;
                  last_q  <= leds_in;
                  byte_q  <= 2'd0;
                  bit_q   <= 3'd0;
                  state_q <= S_START;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            S_START: begin
               if (wrap) begin
                  cnt_q   <= '0;
                  bit_q   <= 3'd0;
                  state_q <= S_DATA;
                  tx_q    <= cur_byte[0];
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_DATA: begin
               if (wrap) begin
                  cnt_q <= '0;
                  if (bit_q == 3'd7) begin
                     state_q <= S_STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     bit_q <= nxt_bit;
                     tx_q  <= cur_byte[nxt_bit];
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_STOP: begin
               if (wrap) begin
                  cnt_q <= '0;
                  if (byte_q == LAST_BYT) begin
                     state_q <= S_IDLE;
                     tx_q    <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     byte_q  <= byte_q + 2'd1;
                     state_q <= S_START;
                     tx_q    <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tx   = tx_q;
   assign busy = busy_q;

endmodule
